sram_burst_ctrl: RTL and testbench

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

---
 rtl/sram_burst_ctrl_pkg.sv | 28 ++
 rtl/sram_rd_fifo.sv | 66 ++++++
 rtl/sram_burst_ctrl.sv | 145 ++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl_pkg
// Description : Shared FSM state encoding and the log2 helper used by the
//               SRAM burst controller and its read FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_burst_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WR    = 2'd1,
      S_RD    = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   // Ceiling log2, never below 1 so a one-word memory still gets an address bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_fifo
// Description : Two-entry read-data FIFO with push, pop, occupancy count and
//               a head-of-queue output. Simultaneous push and pop keeps the
//               count and the ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_fifo #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_dt_i,
   input  logic                  pop_i,
   output logic [1:0]            count_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;
   logic                  w_pop;
   logic                  w_push;

   // A pop frees a slot in the same cycle, so a full FIFO may push while popping.
   assign w_pop   = pop_i && (count_q != 2'd0);
   assign w_push  = push_i && ((count_q != 2'd2) || w_pop);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Occupancy update from the push/pop pair.
   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and count; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (w_push) begin
            mem_q[wr_ptr_q] <= push_dt_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl
// Description : Burst controller for a single-port synchronous SRAM. Accepts
//               write/read burst commands, streams write beats straight to
//               the SRAM and buffers read returns in a 2-entry FIFO with
//               back-pressure on issue.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_ctrl
   import sram_burst_ctrl_pkg::*;
#(
   parameter int SRAM_DEPTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = clog2(SRAM_DEPTH)
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iCmdVld,
   output logic                  oCmdRdy,
   input  logic                  iCmdWr,
   input  logic [ADDR_WIDTH-1:0] iCmdAddr,
   input  logic [ADDR_WIDTH-1:0] iCmdLen,
   input  logic                  iWrVld,
   output logic                  oWrRdy,
   input  logic [DATA_WIDTH-1:0] iWrDt,
   output logic                  oRdVld,
   input  logic                  iRdRdy,
   output logic [DATA_WIDTH-1:0] oRdDt,
   output logic                  oBusy,
   output logic                  oCsn,
   output logic                  oWrn,
   output logic [ADDR_WIDTH-1:0] oAddr,
   output logic [DATA_WIDTH-1:0] oWrDt,
   input  logic [DATA_WIDTH-1:0] iRdDt
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] rem_q, rem_d;
   logic                  infl_q, infl_d;

   logic [1:0]            w_fifo_cnt;
   logic                  w_pop;
   logic [2:0]            w_occ;
   logic                  w_can_issue;
   logic [ADDR_WIDTH-1:0] w_addr_inc;

   assign oRdVld = (w_fifo_cnt != 2'd0);
   assign w_pop  = oRdVld && iRdRdy;
   assign oBusy  = (state_q != S_IDLE);

   // Slots already committed (buffered + in flight) after this cycle's pop.
   assign w_occ       = {1'b0, w_fifo_cnt} + {2'b00, infl_q} - {2'b00, w_pop};
   assign w_can_issue = (w_occ < 3'd2);

   // Explicit wrap so non-power-of-two depths also roll over to 0.
   assign w_addr_inc = (addr_q == ADDR_WIDTH'(SRAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

   // Read returns arrive one cycle after issue; the in-flight flag is the push strobe.
   sram_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_fifo (
      .clk_i     (iClk),
      .rst_i     (iRst),
      .push_i    (infl_q),
      .push_dt_i (iRdDt),
      .pop_i     (w_pop),
      .count_o   (w_fifo_cnt),
      .head_o    (oRdDt)
   );

   // Next-state, burst bookkeeping and SRAM strobes; idle bus values are the defaults.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      infl_d  = 1'b0;
      oCmdRdy = 1'b0;
      oWrRdy  = 1'b0;
      oCsn    = 1'b1;
      oWrn    = 1'b1;
      oAddr   = '0;
      oWrDt   = '0;
      case (state_q)
         S_IDLE: begin
            oCmdRdy = 1'b1;
            if (iCmdVld) begin
               addr_d  = iCmdAddr;
               rem_d   = iCmdLen;
               state_d = iCmdWr ? S_WR : S_RD;
            end
         end
         S_WR: begin
            oWrRdy = 1'b1;
            if (iWrVld) begin
               oCsn   = 1'b0;
               oWrn   = 1'b0;
               oAddr  = addr_q;
               oWrDt  = iWrDt;
               addr_d = w_addr_inc;
               rem_d  = rem_q - 1'b1;
               if (rem_q == '0) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RD: begin
            if (w_can_issue) begin
               oCsn   = 1'b0;
               oAddr  = addr_q;
               infl_d = 1'b1;
               addr_d = w_addr_inc;
               rem_d  = rem_q - 1'b1;
               if (rem_q == '0) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((w_fifo_cnt == 2'd0) && !infl_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any outstanding read so its return is ignored.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         infl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         infl_q  <= infl_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_burst_ctrl
// Description : Scoreboard bench for sram_burst_ctrl with a behavioural
//               single-port SRAM. Stimulus pushes expected SRAM writes,
//               read addresses and read data; a negedge monitor pops and
//               compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iCmdVld = 1'b0;
   logic          oCmdRdy;
   logic          iCmdWr = 1'b0;
   logic [AW-1:0] iCmdAddr = '0;
   logic [AW-1:0] iCmdLen = '0;
   logic          iWrVld = 1'b0;
   logic          oWrRdy;
   logic [DW-1:0] iWrDt = '0;
   logic          oRdVld;
   logic          iRdRdy = 1'b0;
   logic [DW-1:0] oRdDt;
   logic          oBusy;
   logic          oCsn;
   logic          oWrn;
   logic [AW-1:0] oAddr;
   logic [DW-1:0] oWrDt;
   logic [DW-1:0] iRdDt;

   sram_burst_ctrl #(
      .SRAM_DEPTH (DEPTH),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iCmdVld  (iCmdVld),
      .oCmdRdy  (oCmdRdy),
      .iCmdWr   (iCmdWr),
      .iCmdAddr (iCmdAddr),
      .iCmdLen  (iCmdLen),
      .iWrVld   (iWrVld),
      .oWrRdy   (oWrRdy),
      .iWrDt    (iWrDt),
      .oRdVld   (oRdVld),
      .iRdRdy   (iRdRdy),
      .oRdDt    (oRdDt),
      .oBusy    (oBusy),
      .oCsn     (oCsn),
      .oWrn     (oWrn),
      .oAddr    (oAddr),
      .oWrDt    (oWrDt),
      .iRdDt    (iRdDt)
   );

   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   // Single-port SRAM model, reset tied inactive: registered read data.
   logic [DW-1:0] sram [DEPTH];
   logic [DW-1:0] sram_rd_q = '0;
   assign iRdDt = sram_rd_q;
   always @(posedge iClk) begin
      if (!oCsn) begin
         if (!oWrn) sram[oAddr] <= oWrDt;
         else       sram_rd_q   <= sram[oAddr];
      end
   end

   // Scoreboard state
   logic [AW+DW-1:0] wq [$];
   logic [AW-1:0]    raq [$];
   logic [DW-1:0]    rq [$];
   int               beat_cyc [$];
   logic [DW-1:0]    exp_mem [DEPTH];
   logic [AW+DW-1:0] mon_e;
   int               n_checks = 0;
   int               n_fail = 0;
   int               acc_cyc = 0;
   int               iss = 0;
   int               con = 0;
   int               occ;
   logic             stall_q = 1'b0;
   logic [DW-1:0]    stall_dt = '0;
   bit               rd_done = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=access required=none (cycle %0d)", nm, cyc);
   endtask

   // Monitor: compares every SRAM access and every consumed read beat.
   always @(negedge iClk) begin
      if (iRst) begin
         iss     = 0;
         con     = 0;
         stall_q = 1'b0;
      end else begin
         if (!oCsn && !oWrn) begin
            if (wq.size() == 0) unexpected("wr_unexpected");
            else begin
               mon_e = wq.pop_front();
               chk("wr_addr", 64'(oAddr), 64'(mon_e[AW+DW-1:DW]));
               chk("wr_data", 64'(oWrDt), 64'(mon_e[DW-1:0]));
            end
         end
         if (!oCsn && oWrn) begin
            occ = iss - con - ((oRdVld && iRdRdy) ? 1 : 0) + 1;
            chk("rd_outstanding_le2", 64'(occ <= 2), 64'd1);
            if (raq.size() == 0) unexpected("rd_unexpected");
            else chk("rd_addr", 64'(oAddr), 64'(raq.pop_front()));
            iss++;
         end
         if (stall_q) chk("stall_hold", 64'({oRdVld, oRdDt}), 64'({1'b1, stall_dt}));
         if (oRdVld && iRdRdy) begin
            beat_cyc.push_back(cyc);
            con++;
            if (rq.size() == 0) unexpected("rd_beat_unexpected");
            else chk("rd_data", 64'(oRdDt), 64'(rq.pop_front()));
         end
         stall_q  = oRdVld && !iRdRdy;
         stall_dt = oRdDt;
      end
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
      iCmdVld  = 1'b1;
      iCmdWr   = wr;
      iCmdAddr = a;
      iCmdLen  = l;
      #1;
      chk("cmd_rdy", 64'(oCmdRdy), 64'd1);
      acc_cyc = cyc;
      tick();
      iCmdVld  = 1'b0;
      iCmdWr   = 1'b0;
      iCmdAddr = '0;
      iCmdLen  = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                           input logic [DW-1:0] base, input int dly);
      for (int i = 0; i <= int'(l); i++) begin
         automatic logic [AW-1:0] ad = a + AW'(i);
         wq.push_back({ad, DW'(base + DW'(i))});
         exp_mem[ad] = DW'(base + DW'(i));
      end
      cmd(1'b1, a, l);
      repeat (dly) begin
         chk("wr_wait_idle_bus", 64'({oCsn, oWrRdy, oBusy, oRdVld}), 64'(4'b1110));
         tick();
      end
      for (int i = 0; i <= int'(l); i++) begin
         iWrVld = 1'b1;
         iWrDt  = DW'(base + DW'(i));
         #1;
         chk("wr_rdy", 64'(oWrRdy), 64'd1);
         tick();
      end
      iWrVld = 1'b0;
      iWrDt  = '0;
      chk("wr_back_to_idle", 64'(oBusy), 64'd0);
      chk("wr_all_seen", 64'(wq.size()), 64'd0);
   endtask

   task automatic exp_read(input logic [AW-1:0] a, input logic [AW-1:0] l);
      for (int i = 0; i <= int'(l); i++) begin
         automatic logic [AW-1:0] ad = a + AW'(i);
         raq.push_back(ad);
         rq.push_back(exp_mem[ad]);
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l);
      int n;
      exp_read(a, l);
      cmd(1'b0, a, l);
      n = 0;
      while (oBusy && n < 100) begin
         tick();
         n++;
      end
      chk("rd_idle_within_bound", 64'(oBusy), 64'd0);
      chk("rd_all_beats", 64'(rq.size()), 64'd0);
      chk("rd_all_addrs", 64'(raq.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         sram[i]    = '0;
         exp_mem[i] = '0;
      end

      // Reset state
      repeat (3) @(posedge iClk);
      #1;
      chk("reset_ctrl", 64'({oCmdRdy, oWrRdy, oRdVld, oBusy, oCsn, oWrn}), 64'(6'b100011));
      chk("reset_data", 64'({oAddr, oWrDt, oRdDt}), 64'd0);
      iRst = 1'b0;

      // Write burst right after reset release: addr 2..5
      do_write(4'd2, 4'd3, 32'hA0, 0);

      // Read burst with latency check: beats at T+3..T+6
      iRdRdy = 1'b1;
      beat_cyc.delete();
      do_read(4'd2, 4'd3);
      chk("rd_beat_count", 64'(beat_cyc.size()), 64'd4);
      if (beat_cyc.size() == 4) begin
         chk("rd_first_latency", 64'(beat_cyc[0] - acc_cyc), 64'd3);
         chk("rd_last_latency", 64'(beat_cyc[3] - acc_cyc), 64'd6);
      end

      // Wrapping write and read: 14,15,0,1
      do_write(4'd14, 4'd3, 32'h1, 0);
      do_read(4'd14, 4'd3);

      // Back-pressure: read 0..7 with iRdRdy pattern 1,0,0,1
      do_write(4'd6, 4'd1, 32'hB6, 0);
      rd_done = 1'b0;
      fork
         begin
            do_read(4'd0, 4'd7);
            rd_done = 1'b1;
         end
         begin
            automatic logic [3:0] pat = 4'b1001;
            automatic int k = 0;
            while (!rd_done) begin
               iRdRdy = pat[k % 4];
               k++;
               tick();
            end
         end
      join
      iRdRdy = 1'b1;

      // Reset pulsed at the second beat of a len=7 read
      exp_read(4'd0, 4'd7);
      cmd(1'b0, 4'd0, 4'd7);
      tick();
      tick();
      tick();
      chk("rst_pre_beat2_vld", 64'(oRdVld), 64'd1);
      chk("rst_pre_one_beat_taken", 64'(rq.size()), 64'd7);
      iRst = 1'b1;
      #1;
      chk("rst_mid_ctrl", 64'({oCmdRdy, oWrRdy, oRdVld, oBusy, oCsn, oWrn}), 64'(6'b100011));
      chk("rst_mid_data", 64'({oAddr, oWrDt, oRdDt}), 64'd0);
      wq.delete();
      raq.delete();
      rq.delete();
      tick();
      iRst = 1'b0;

      // First command after reset, len=0 write with iWrVld delayed 3 cycles
      do_write(4'd9, 4'd0, 32'hC9, 3);
      do_read(4'd9, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
